// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, next-PC selection, HALT latch and a
// word-addressed instruction memory that the Debug Unit loads through a write port.
module if_stage #(
    parameter int         NB_PC        = 32,
    parameter int         NB_INST      = 32,
    parameter int         IMEM_DEPTH   = 256,
    parameter int         NB_IMEM_ADDR = 8,
    parameter logic [5:0] HALT_OPCODE  = 6'b111111
) (
    input  logic                    i_clock,
    input  logic                    i_IF_reset,
    input  logic                    i_IF_enable,
    input  logic                    i_IF_stall,
    input  logic                    i_IF_branch,
    input  logic [NB_PC-1:0]        i_IF_branch_addr,
    input  logic                    i_IF_jump,
    input  logic [NB_PC-1:0]        i_IF_jump_addr,
    input  logic                    i_IF_jr_jalr,
    input  logic [NB_PC-1:0]        i_IF_jr_addr,
    input  logic                    i_IF_wr_enable,
    input  logic [NB_IMEM_ADDR-1:0] i_IF_wr_addr,
    input  logic [NB_INST-1:0]      i_IF_wr_data,
    output logic [NB_INST-1:0]      o_IF_inst,
    output logic [NB_PC-1:0]        o_IF_pc,
    output logic [NB_PC-1:0]        o_IF_next_pc,
    output logic                    o_IF_halted,
    output logic                    o_IF_imem_last
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    logic [NB_PC-1:0]        pc_q;
    logic [NB_PC-1:0]        pc_d;
    logic [0:0]              state_q;
    logic [0:0]              state_d;
    logic [NB_INST-1:0]      imem_q [IMEM_DEPTH];

    logic [NB_IMEM_ADDR-1:0] fetch_idx_s;
    logic [NB_INST-1:0]      inst_s;
    logic [NB_PC-1:0]        seq_pc_s;
    logic                    halt_fetch_s;
    logic                    advance_s;
    logic                    redirect_s;
    logic [NB_PC-1:0]        redirect_pc_s;

    // The fetch address wraps at the memory depth while the PC keeps counting.
    assign fetch_idx_s  = pc_q[NB_IMEM_ADDR-1:0];
    assign inst_s       = imem_q[fetch_idx_s];
    assign seq_pc_s     = pc_q + {{(NB_PC-1){1'b0}}, 1'b1};
    assign halt_fetch_s = (inst_s[NB_INST-1 -: 6] == HALT_OPCODE);
    assign advance_s    = i_IF_enable & ~i_IF_stall;

    // Redirect select: register target beats jump, jump beats branch.
    always_comb begin
        redirect_s    = 1'b0;
        redirect_pc_s = seq_pc_s;
        if (i_IF_jr_jalr) begin
            redirect_s    = 1'b1;
            redirect_pc_s = i_IF_jr_addr;
        end else if (i_IF_jump) begin
            redirect_s    = 1'b1;
            redirect_pc_s = i_IF_jump_addr;
        end else if (i_IF_branch) begin
            redirect_s    = 1'b1;
            redirect_pc_s = i_IF_branch_addr;
        end else begin
            redirect_s    = 1'b0;
            redirect_pc_s = seq_pc_s;
        end
    end

    // Next PC and RUN/HALTED state; a HALT on a redirected path is squashed.
    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (!advance_s) begin
                    pc_d    = pc_q;
                    state_d = ST_RUN;
                end else if (redirect_s) begin
                    pc_d    = redirect_pc_s;
                    state_d = ST_RUN;
                end else if (halt_fetch_s) begin
                    pc_d    = pc_q;
                    state_d = ST_HALTED;
                end else begin
                    pc_d    = seq_pc_s;
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                pc_d    = pc_q;
                state_d = ST_HALTED;
            end
            default: begin
                pc_d    = pc_q;
                state_d = ST_HALTED;
            end
        endcase
    end

    // PC and state registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_IF_reset) begin
            pc_q    <= {NB_PC{1'b0}};
            state_q <= ST_RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    // Debug Unit write port; contents survive reset so a loaded program persists.
    always_ff @(posedge i_clock) begin
        if (i_IF_wr_enable) begin
            imem_q[i_IF_wr_addr] <= i_IF_wr_data;
        end
    end

    assign o_IF_inst      = inst_s;
    assign o_IF_pc        = pc_q;
    assign o_IF_next_pc   = seq_pc_s;
    assign o_IF_halted    = (state_q == ST_HALTED);
    assign o_IF_imem_last = (fetch_idx_s == NB_IMEM_ADDR'(IMEM_DEPTH - 1));

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, hand-written corner sequences and
// randomized traffic checked against a behavioural fetch model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst, en, stall, br, jmp, jr, wr;
    logic [31:0] br_a, j_a, jr_a, wd;
    logic [7:0]  wa;
    logic [31:0] o_inst, o_pc, o_next_pc;
    logic        o_halted, o_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .i_clock          (clk),
        .i_IF_reset       (rst),
        .i_IF_enable      (en),
        .i_IF_stall       (stall),
        .i_IF_branch      (br),
        .i_IF_branch_addr (br_a),
        .i_IF_jump        (jmp),
        .i_IF_jump_addr   (j_a),
        .i_IF_jr_jalr     (jr),
        .i_IF_jr_addr     (jr_a),
        .i_IF_wr_enable   (wr),
        .i_IF_wr_addr     (wa),
        .i_IF_wr_data     (wd),
        .o_IF_inst        (o_inst),
        .o_IF_pc          (o_pc),
        .o_IF_next_pc     (o_next_pc),
        .o_IF_halted      (o_halted),
        .o_IF_imem_last   (o_last)
    );

    typedef struct {
        logic        rst, en, stall, br;
        logic [31:0] ba;
        logic        jmp;
        logic [31:0] ja;
        logic        jr;
        logic [31:0] jra;
        logic        wr;
        logic [7:0]  wa;
        logic [31:0] wd;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic [31:0] pc;
        logic        h;
        logic        last;
        logic        ci;
        logic [31:0] inst;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] prog [4] = '{32'h2001_0005, 32'h2002_0007, 32'h0022_1820, 32'hFC00_0000};

    // Behavioural model: whole-memory array, PC and halt flag.
    logic [31:0] m_mem [256];
    logic [31:0] m_pc;
    logic        m_halted;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic stim_t mk(input logic r, input logic e, input logic st, input logic b,
                                 input logic [31:0] ba, input logic j, input logic [31:0] ja,
                                 input logic jrr, input logic [31:0] jra);
        stim_t s;
        s.rst = r; s.en = e; s.stall = st; s.br = b; s.ba = ba;
        s.jmp = j; s.ja = ja; s.jr = jrr; s.jra = jra;
        s.wr = 1'b0; s.wa = 8'd0; s.wd = 32'd0;
        return s;
    endfunction

    function automatic logic [31:0] rand_nohalt();
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] == 6'h3F) w[31:26] = 6'h08;
        return w;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        if ($urandom_range(0, 3) == 0) a = $urandom;
        else a = 32'($urandom_range(0, 300));
        return a;
    endfunction

    task automatic add(input stim_t s, input logic [31:0] pc, input logic h, input logic last,
                       input logic ci, input logic [31:0] inst);
        vec_t v;
        v.s = s; v.pc = pc; v.h = h; v.last = last; v.ci = ci; v.inst = inst;
        vecs.push_back(v);
    endtask

    task automatic model_step(input stim_t s);
        logic [31:0] cur;
        cur = m_mem[8'(m_pc % 32'd256)];
        if (s.rst) begin
            m_pc     = 32'd0;
            m_halted = 1'b0;
        end else if (!m_halted && s.en && !s.stall) begin
            if (s.jr)                     m_pc = s.jra;
            else if (s.jmp)               m_pc = s.ja;
            else if (s.br)                m_pc = s.ba;
            else if (cur[31:26] == 6'h3F) m_halted = 1'b1;
            else                          m_pc = m_pc + 32'd1;
        end
        if (s.wr) m_mem[s.wa] = s.wd;
    endtask

    task automatic do_cycle(input stim_t s);
        rst = s.rst; en = s.en; stall = s.stall;
        br = s.br; br_a = s.ba; jmp = s.jmp; j_a = s.ja; jr = s.jr; jr_a = s.jra;
        wr = s.wr; wa = s.wa; wd = s.wd;
        @(posedge clk);
        model_step(s);
        #1;
        chk("model_pc", o_pc, m_pc);
        chk("model_inst", o_inst, m_mem[8'(m_pc % 32'd256)]);
        chk("model_next_pc", o_next_pc, m_pc + 32'd1);
        chk("model_halted", 32'(o_halted), 32'(m_halted));
        chk("model_last", 32'(o_last), 32'((m_pc % 32'd256) == 32'd255));
    endtask

    initial begin
        stim_t s;
        m_pc = 32'd0;
        m_halted = 1'b0;

        // Load every word (program in 0..3) while reset is held; writes ignore reset.
        for (int a = 0; a < 256; a++) begin
            s = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
            s.wr = 1'b1;
            s.wa = 8'(a);
            s.wd = (a < 4) ? prog[a] : rand_nohalt();
            do_cycle(s);
        end

        add(mk(1,0,0,0,0,0,0,0,0),                   32'd0,   0, 0, 1, 32'h2001_0005);
        add(mk(0,1,0,0,0,0,0,0,0),                   32'd1,   0, 0, 1, 32'h2002_0007);
        add(mk(0,1,0,0,0,0,0,0,0),                   32'd2,   0, 0, 1, 32'h0022_1820);
        add(mk(0,1,0,0,0,0,0,0,0),                   32'd3,   0, 0, 1, 32'hFC00_0000);
        add(mk(0,1,0,0,0,0,0,0,0),                   32'd3,   1, 0, 1, 32'hFC00_0000);
        add(mk(0,1,0,0,0,0,0,0,0),                   32'd3,   1, 0, 1, 32'hFC00_0000);
        add(mk(0,1,0,0,0,1,32'h10,0,0),              32'd3,   1, 0, 0, 32'd0);
        add(mk(1,1,0,0,0,1,32'h99,0,0),              32'd0,   0, 0, 1, 32'h2001_0005);
        add(mk(0,1,0,0,0,1,32'h5,0,0),               32'h5,   0, 0, 0, 32'd0);
        add(mk(0,1,0,1,32'h20,1,32'h10,0,0),         32'h10,  0, 0, 0, 32'd0);
        add(mk(0,1,0,0,0,1,32'h5,0,0),               32'h5,   0, 0, 0, 32'd0);
        add(mk(0,1,0,1,32'h20,1,32'h10,1,32'h30),    32'h30,  0, 0, 0, 32'd0);
        add(mk(0,1,0,1,32'h7,0,0,0,0),               32'h7,   0, 0, 0, 32'd0);
        add(mk(0,1,1,1,32'h40,0,0,0,0),              32'h7,   0, 0, 0, 32'd0);
        add(mk(0,1,1,1,32'h40,0,0,0,0),              32'h7,   0, 0, 0, 32'd0);
        add(mk(0,1,0,1,32'h40,0,0,0,0),              32'h40,  0, 0, 0, 32'd0);
        add(mk(0,1,0,0,0,1,32'h2,0,0),               32'h2,   0, 0, 1, 32'h0022_1820);
        add(mk(0,0,0,0,0,0,0,0,0),                   32'h2,   0, 0, 0, 32'd0);
        add(mk(0,0,0,0,0,1,32'h10,0,0),              32'h2,   0, 0, 0, 32'd0);
        add(mk(0,0,0,0,0,0,0,0,0),                   32'h2,   0, 0, 0, 32'd0);
        add(mk(0,1,0,0,0,0,0,0,0),                   32'h3,   0, 0, 1, 32'hFC00_0000);
        add(mk(0,1,1,0,0,0,0,0,0),                   32'h3,   0, 0, 1, 32'hFC00_0000);
        add(mk(0,1,0,1,32'h20,0,0,0,0),              32'h20,  0, 0, 0, 32'd0);
        add(mk(0,1,0,0,0,1,32'hFF,0,0),              32'hFF,  0, 1, 0, 32'd0);
        add(mk(0,1,0,0,0,0,0,0,0),                   32'h100, 0, 0, 1, 32'h2001_0005);
        add(mk(0,1,0,0,0,0,0,0,0),                   32'h101, 0, 0, 1, 32'h2002_0007);

        foreach (vecs[i]) begin
            do_cycle(vecs[i].s);
            chk($sformatf("vec%0d_pc", i), o_pc, vecs[i].pc);
            chk($sformatf("vec%0d_halted", i), 32'(o_halted), 32'(vecs[i].h));
            chk($sformatf("vec%0d_last", i), 32'(o_last), 32'(vecs[i].last));
            if (vecs[i].ci) chk($sformatf("vec%0d_inst", i), o_inst, vecs[i].inst);
        end

        // Write a HALT word over the fetched address during a stall, then let it halt.
        s = mk(0,1,1,0,0,0,0,0,0); s.wr = 1'b1; s.wa = 8'd1; s.wd = 32'hFC00_0123;
        do_cycle(s);
        chk("wr_cur_inst", o_inst, 32'hFC00_0123);
        chk("wr_cur_pc", o_pc, 32'h101);
        chk("wr_cur_halted", 32'(o_halted), 32'd0);
        do_cycle(mk(0,1,0,0,0,0,0,0,0));
        chk("wr_halt_halted", 32'(o_halted), 32'd1);
        chk("wr_halt_pc", o_pc, 32'h101);
        s = mk(0,0,0,0,0,0,0,0,0); s.wr = 1'b1; s.wa = 8'd1; s.wd = 32'h2002_0007;
        do_cycle(s);
        chk("wr_halted_inst", o_inst, 32'h2002_0007);
        chk("wr_halted_still", 32'(o_halted), 32'd1);

        // Reset beats stall, disable and a pending register redirect.
        do_cycle(mk(1,0,1,0,0,0,0,1,32'h55));
        chk("rst_prio_pc", o_pc, 32'd0);
        chk("rst_prio_halted", 32'(o_halted), 32'd0);
        chk("rst_prio_next", o_next_pc, 32'd1);

        for (int n = 0; n < 3000; n++) begin
            s.rst   = ($urandom_range(0, 39) == 0);
            s.en    = ($urandom_range(0, 7) != 0);
            s.stall = ($urandom_range(0, 5) == 0);
            s.br    = ($urandom_range(0, 7) == 0);
            s.ba    = rand_addr();
            s.jmp   = ($urandom_range(0, 7) == 0);
            s.ja    = rand_addr();
            s.jr    = ($urandom_range(0, 7) == 0);
            s.jra   = rand_addr();
            s.wr    = ($urandom_range(0, 3) == 0);
            s.wa    = ($urandom_range(0, 3) == 0) ? 8'(m_pc) : 8'($urandom_range(0, 255));
            s.wd    = ($urandom_range(0, 7) == 0) ? {6'h3F, 26'($urandom)} : rand_nohalt();
            do_cycle(s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage, directly upstream of the instruction-decode stage. It feeds decode with the fetched instruction and PC+1 through the IF/ID latch.
- Holds the program counter and a word-addressed instruction memory. The Debug Unit loads that memory before execution.
- Selects the next PC from: sequential, branch target, jump target (J/JAL) or register target (JR/JALR from decode's r31/rs data).
- Supports stall (hazard unit), step/run enable (Debug Unit) and latching of HALT.

Parameters:
NB_PC, 32, PC / address width
NB_INST, 32, instruction width
IMEM_DEPTH, 256, instruction memory depth in words (power of 2)
NB_IMEM_ADDR, 8, log2(IMEM_DEPTH)
HALT_OPCODE, 6'b111111, opcode (inst[31:26]) of HALT

Ports:
i_clock  in  1  clock; all state updates on rising edge
i_IF_reset  in  1  synchronous, active-high reset
i_IF_enable  in  1  Debug Unit run/step enable; 0 freezes PC and halt state
i_IF_stall  in  1  hazard-unit stall; 1 holds PC
i_IF_branch  in  1  taken-branch select from MEM
i_IF_branch_addr  in  NB_PC  branch target
i_IF_jump  in  1  J/JAL select from ID
i_IF_jump_addr  in  NB_PC  jump target from ID
i_IF_jr_jalr  in  1  JR/JALR select from ID
i_IF_jr_addr  in  NB_PC  register target from ID (r31/rs data)
i_IF_wr_enable  in  1  Debug Unit instruction-memory write strobe
i_IF_wr_addr  in  NB_IMEM_ADDR  write word address
i_IF_wr_data  in  NB_INST  write word
o_IF_inst  out  NB_INST  instruction at current PC
o_IF_pc  out  NB_PC  current PC
o_IF_next_pc  out  NB_PC  PC+1 (consumed by ID for jump concat / link)
o_IF_halted  out  1  HALT fetched; stage frozen
o_IF_imem_last  out  1  1 when o_IF_pc[NB_IMEM_ADDR-1:0] == IMEM_DEPTH-1

Behaviour:
- PC is word-addressed: next sequential PC = PC + 1, modulo 2^NB_PC. Memory index = PC[NB_IMEM_ADDR-1:0], so the fetch address wraps at IMEM_DEPTH.
- o_IF_inst is an asynchronous read of mem[PC index], giving 0-cycle latency. o_IF_next_pc = o_IF_pc + 1, combinational.
- Reset (synchronous):
  - PC = 0, o_IF_halted = 0, so o_IF_inst = mem[0] and o_IF_next_pc = 1.
  - Memory contents are NOT cleared, so a program stays loaded across reset.
  - Reset overrides every other input in the same cycle.
- PC update priority on each edge, after reset:
  1. o_IF_halted = 1, or i_IF_enable = 0, or i_IF_stall = 1: PC holds.
  2. i_IF_jr_jalr = 1: PC = i_IF_jr_addr.
  3. i_IF_jump = 1: PC = i_IF_jump_addr.
  4. i_IF_branch = 1: PC = i_IF_branch_addr.
  5. Otherwise: PC = PC + 1.
- Simultaneous selects resolve strictly by the priority above, with no error flag.
- Stall vs redirect: stall wins and the redirect is dropped. The requester must hold its select until the stall drops.
- HALT state machine with states RUN and HALTED:
  - RUN -> HALTED on an edge where enable = 1, stall = 0, no redirect is selected, and o_IF_inst[31:26] == HALT_OPCODE.
  - In that transition PC does NOT advance; it stays on the HALT word.
  - HALTED -> RUN only via reset.
  - o_IF_halted = 1 in HALTED. o_IF_inst keeps showing the HALT word so the pipeline drains behind it.
  - If a redirect is selected in the same cycle HALT is fetched, the HALT is on a squashed path: take the redirect and stay in RUN.
- Memory write: on an edge with i_IF_wr_enable = 1, mem[i_IF_wr_addr] = i_IF_wr_data.
  - Writes are allowed in any state and ignore enable/stall/reset.
  - A write to the currently fetched address changes o_IF_inst from the next cycle.
- Reset mid-run or while HALTED: PC = 0 and RUN next cycle; in-flight redirects are discarded.

Test Plan:
- Load mem[0..3] = 0x20010005, 0x20020007, 0x00221820, 0xFC000000 via the write port; reset; enable = 1 -> PC 0,1,2,3; o_IF_halted = 1 from the cycle after PC = 3, PC frozen at 3, o_IF_inst = 0xFC000000.
- At PC = 5, assert jump = 1 (addr 0x10) and branch = 1 (addr 0x20) together -> next PC = 0x10. Repeat with jr_jalr = 1 (addr 0x30) also asserted -> next PC = 0x30.
- At PC = 7, stall = 1 for 2 cycles with branch = 1 (addr 0x40) -> PC stays 7 both cycles. Keep branch asserted one more cycle after stall drops -> PC = 0x40.
- enable = 0 for 3 cycles at PC = 2 -> PC stays 2. Re-enable -> PC = 3 the next cycle.
- PC at IMEM_DEPTH-1 = 255 -> o_IF_imem_last = 1. Next edge gives PC = 256, fetching mem[0], with o_IF_imem_last = 0.
- While HALTED, pulse reset for 1 cycle -> PC = 0, o_IF_halted = 0, mem contents intact (o_IF_inst = 0x20010005).
